// File: rtl/rob_commit.sv
// rob_commit: in-order completion buffer (reorder buffer).
//
// Allocates one entry per dispatched instruction, captures results from the
// common data bus out of order, and retires entries strictly in program
// order to the register file write port.  A flush discards every entry.
//
// Ports:
//   i_clock          system clock, rising edge
//   i_reset          synchronous, active-high reset (priority over flush)
//   i_flush          synchronous discard of all entries
//   i_alloc_req      dispatch requests one entry
//   i_alloc_dest     destination register of the dispatched instruction
//   i_alloc_wen      instruction writes a register
//   o_alloc_ack      combinational grant
//   o_alloc_tag      combinational tag of the granted entry (tail pointer)
//   i_cdb_valid      result broadcast valid
//   i_cdb_tag        entry the result belongs to
//   i_cdb_data       result value
//   o_commit_wen     registered register-file write enable
//   o_commit_waddr   registered register-file write address
//   o_commit_data    registered register-file write data
//   o_full           count == DEPTH
//   o_empty          count == 0
//   o_count          number of valid entries
//
// Build option: define ROB_BYPASS_EN to let the head entry retire on the
// same edge its CDB result arrives, taking the data straight off the bus.

module rob_commit #(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 3,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_flush,
    input  logic              i_alloc_req,
    input  logic [ADDR_W-1:0] i_alloc_dest,
    input  logic              i_alloc_wen,
    output logic              o_alloc_ack,
    output logic [TAG_W-1:0]  o_alloc_tag,
    input  logic              i_cdb_valid,
    input  logic [TAG_W-1:0]  i_cdb_tag,
    input  logic [DATA_W-1:0] i_cdb_data,
    output logic              o_commit_wen,
    output logic [ADDR_W-1:0] o_commit_waddr,
    output logic [DATA_W-1:0] o_commit_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [TAG_W:0]    o_count
);

    localparam logic [TAG_W:0] LP_DEPTH = (TAG_W+1)'(DEPTH);

    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_ready;
    logic [DEPTH-1:0]  r_wen;
    logic [ADDR_W-1:0] r_dest [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];

    logic [TAG_W-1:0]  r_head;
    logic [TAG_W-1:0]  r_tail;
    logic [TAG_W:0]    r_count;

    logic              r_commit_wen;
    logic [ADDR_W-1:0] r_commit_waddr;
    logic [DATA_W-1:0] r_commit_data;

    logic              w_full;
    logic              w_empty;
    logic              w_alloc;
    logic              w_cdb_hit;
    logic              w_commit;
    logic [DATA_W-1:0] w_commit_data;
    logic [ADDR_W-1:0] w_head_dest;
    logic              w_head_wen;

    assign w_full  = (r_count == LP_DEPTH);
    assign w_empty = (r_count == '0);

    // Full is judged on the current count only; a commit freeing a slot in
    // the same cycle does not open the door for an allocation.
    assign w_alloc = i_alloc_req & ~w_full & ~i_flush & ~i_reset;

    // Validity is taken from the start of the cycle, so a result aimed at
    // the slot being allocated right now is dropped.
    assign w_cdb_hit = i_cdb_valid & r_valid[i_cdb_tag];

    assign w_head_dest = r_dest[r_head];
    assign w_head_wen  = r_wen[r_head];

`ifdef ROB_BYPASS_EN
    logic w_cdb_head;
    assign w_cdb_head    = i_cdb_valid & (i_cdb_tag == r_head);
    assign w_commit      = r_valid[r_head] & (r_ready[r_head] | w_cdb_head);
    assign w_commit_data = w_cdb_head ? i_cdb_data : r_data[r_head];
`else
    assign w_commit      = r_valid[r_head] & r_ready[r_head];
    assign w_commit_data = r_data[r_head];
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_valid        <= '0;
            r_ready        <= '0;
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_commit_wen   <= 1'b0;
            r_commit_waddr <= '0;
            r_commit_data  <= '0;
        end else if (i_flush) begin
            r_valid      <= '0;
            r_ready      <= '0;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_commit_wen <= 1'b0;
        end else begin
            if (w_cdb_hit) begin
                r_data[i_cdb_tag]  <= i_cdb_data;
                r_ready[i_cdb_tag] <= 1'b1;
            end

            // Placed after the CDB write so a late result to the retiring
            // head cannot leave a stale ready bit behind.
            if (w_commit) begin
                r_valid[r_head] <= 1'b0;
                r_ready[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
                r_commit_wen    <= w_head_wen & (w_head_dest != '0);
                r_commit_waddr  <= w_head_dest;
                r_commit_data   <= w_commit_data;
            end else begin
                r_commit_wen <= 1'b0;
            end

            // Tail can only equal head here when the buffer is empty, so the
            // slot being allocated is never the one being retired.
            if (w_alloc) begin
                r_valid[r_tail] <= 1'b1;
                r_ready[r_tail] <= 1'b0;
                r_wen[r_tail]   <= i_alloc_wen;
                r_dest[r_tail]  <= i_alloc_dest;
                r_tail          <= r_tail + 1'b1;
            end

            case ({w_alloc, w_commit})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_alloc_ack    = w_alloc;
    assign o_alloc_tag    = r_tail;
    assign o_commit_wen   = r_commit_wen;
    assign o_commit_waddr = r_commit_waddr;
    assign o_commit_data  = r_commit_data;
    assign o_full         = w_full;
    assign o_empty        = w_empty;
    assign o_count        = r_count;

endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- In-order completion buffer (reorder buffer) between dispatch/execute and the register file write port.
- Allocates one entry per dispatched instruction and captures results from the common data bus (CDB) out of order.
- Retires entries strictly in program order, driving the register file's Data_In / Waddr / W_en.
- Supports a full flush for branch mispredict recovery.

Parameters:
- DEPTH, 8, number of entries; must be a power of two, at least 2.
- TAG_W, 3, log2(DEPTH); width of entry tags and of the head/tail pointers.
- DATA_W, 32, result width.
- ADDR_W, 5, architectural register address width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous discard of all entries.
- alloc_req  in  1  dispatch requests one entry.
- alloc_dest  in  ADDR_W  destination register of the dispatched instruction.
- alloc_wen  in  1  instruction writes a register (0 for store/branch).
- alloc_ack  out  1  combinational; entry granted this cycle.
- alloc_tag  out  TAG_W  combinational; tag of the granted entry (tail pointer).
- cdb_valid  in  1  result broadcast valid.
- cdb_tag  in  TAG_W  entry the result belongs to.
- cdb_data  in  DATA_W  result value.
- commit_wen  out  1  registered; to register file W_en.
- commit_waddr  out  ADDR_W  registered; to register file Waddr.
- commit_data  out  DATA_W  registered; to register file Data_In.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  TAG_W+1  number of valid entries.

Behaviour:
- Entry state: valid, ready, wen, dest, data.
- Pointers: head and tail, TAG_W bits, wrap modulo DEPTH. count is held in a separate register.
- Reset (synchronous, clock edge with reset=1):
  - all valid/ready bits cleared; head=tail=count=0.
  - commit_wen=0, commit_waddr=0, commit_data=0.
  - empty=1, full=0, alloc_tag=0.
  - alloc_ack=0 whenever reset is high.
- Allocate: alloc_ack = alloc_req & ~full & ~flush & ~reset. On the edge with alloc_ack=1:
  - entry[tail] is written with valid=1, ready=0, wen=alloc_wen, dest=alloc_dest.
  - tail increments.
- full uses the current count. An allocation is rejected when full, even if a commit frees an entry in the same cycle (no bypass).
- CDB capture: on an edge with cdb_valid=1 and entry[cdb_tag].valid=1 (state at start of cycle), data=cdb_data and ready=1.
  - A CDB to an invalid entry is silently dropped.
  - A repeated CDB to a ready entry overwrites data.
- Commit: on an edge where entry[head].valid & entry[head].ready:
  - the entry is cleared and head increments.
  - commit_waddr = dest and commit_data = data, registered.
  - commit_wen = wen & (dest != 0); r0 is never written.
  - Maximum one commit per cycle.
- When no commit occurs, commit_wen=0 on the next cycle. commit_waddr/commit_data hold their last values.
- Latency without the optional feature:
  - CDB at edge N sets ready.
  - Commit at edge N+1 if the entry is head.
  - commit_wen is high in the cycle following edge N+1.
- Simultaneous alloc + commit: count unchanged; both pointers advance.
- CDB to the head entry in the same cycle as the commit check: ready is not yet visible, so commit happens next cycle.
- Flush (synchronous, priority over alloc, CDB and commit in the same cycle):
  - all valid bits cleared; head=tail=count=0.
  - commit_wen=0 in the following cycle.
- Reset has priority over flush. Reset mid-operation discards all in-flight entries with no commit.

Optional Feature:
- Macro ROB_BYPASS_EN.
- Defined: the head commits on the same edge its CDB result arrives. The condition becomes valid & (ready | (cdb_valid & cdb_tag==head)), and commit_data takes cdb_data directly. This saves one cycle of latency.
- Undefined: behaviour exactly as above; a result always spends at least one cycle in the buffer.

Test Plan:
- Reset then idle -> empty=1, full=0, count=0, commit_wen=0, alloc_tag=0.
- Allocate dest 3 (tag 0) and dest 4 (tag 1); CDB tag1=0xBBBB then tag0=0xAAAA -> commits in order: (waddr 3, data 0xAAAA), then (waddr 4, data 0xBBBB), on consecutive cycles.
- Allocate 8 entries -> full=1, count=8. Ninth alloc_req gives alloc_ack=0. Alloc+commit in the same cycle with count=7 keeps count=7. Tail wraps 7->0.
- Allocate dest 0 with wen=1 and dest 5 with wen=0, then complete both -> both retire; commit_wen stays 0 for both.
- Allocate 3 entries, complete 1, assert flush with alloc_req and cdb_valid high -> alloc_ack=0, count=0, empty=1, no commit_wen. Next alloc returns tag 0.
- With ROB_BYPASS_EN: head tag 0, CDB tag0=0x1234 at edge N -> commit_wen=1, commit_data=0x1234 in the cycle after edge N. Without the macro, this occurs one cycle later.
